// File: rtl/rst_seq_pkg.sv
// Shared types and limits for the reset sequencer.
package rst_seq_pkg;

  localparam int MAX_DOMAINS = 8;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input; clears to 0 on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset release after PLL lock, with all-at-once re-assertion on abort.
// Optional button debounce path enabled by defining RST_SEQ_BTN_DEBOUNCE_EN.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS     = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   locked,
  input  logic                   sw_rst_req,
  input  logic                   btn_rst_n,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   ready
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic locked_s;
  logic btn_abort;
  logic abort;

  sync_ff #(.STAGES(SYNC_STAGES)) u_locked_sync (
    .clock (clock),
    .reset (reset),
    .d     (locked),
    .q     (locked_s)
  );

`ifdef RST_SEQ_BTN_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic            btn_s;
  logic            db_level;
  logic [DB_W-1:0] db_cnt;

  sync_ff #(.STAGES(SYNC_STAGES)) u_btn_sync (
    .clock (clock),
    .reset (reset),
    .d     (btn_rst_n),
    .q     (btn_s)
  );

  // db_level starts released so the synchroniser's post-reset zeros never look like a press
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_level <= 1'b1;
      db_cnt   <= '0;
    end else if (btn_s == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_level <= btn_s;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign btn_abort = ~db_level;
`else
  logic btn_unused;
  assign btn_unused = btn_rst_n & (DEBOUNCE_CYCLES > 0);
  assign btn_abort  = 1'b0;
`endif

  assign abort = ~locked_s | sw_rst_req | btn_abort;

  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [NUM_DOMAINS-1:0] rst_nx;
  logic                   ready_nx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= HOLD;
      cnt     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rst_out <= rst_nx;
      ready   <= ready_nx;
    end
  end

  // Release order is a left shift of the reset vector: bit 0 drops first
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rst_nx   = rst_out;
    ready_nx = ready;
    if (abort) begin
      state_nx = HOLD;
      cnt_nx   = '0;
      rst_nx   = '1;
      ready_nx = 1'b0;
    end else begin
      case (state)
        HOLD: begin
          rst_nx   = '1;
          ready_nx = 1'b0;
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt_nx = '0;
            rst_nx = {NUM_DOMAINS{1'b1}} << 1;
            if (rst_nx == '0) begin
              state_nx = RUN;
              ready_nx = 1'b1;
            end else begin
              state_nx = RELEASE;
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt == CNT_W'(STAGE_GAP - 1)) begin
            cnt_nx = '0;
            rst_nx = rst_out << 1;
            if (rst_nx == '0) begin
              state_nx = RUN;
              ready_nx = 1'b1;
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        RUN: begin
          state_nx = RUN;
        end
        default: begin
          state_nx = HOLD;
          cnt_nx   = '0;
          rst_nx   = '1;
          ready_nx = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: expected (edge, rst_out, ready) points are queued, then checked per edge.
module tb_rst_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       locked = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       btn_rst_n = 1'b1;
  logic [2:0] rst_out;
  logic       ready;

  logic       locked1 = 1'b0;
  logic       sw1 = 1'b0;
  logic       btn1 = 1'b1;
  logic [0:0] rst1;
  logic       ready1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         edge_n;
    logic [2:0] rst;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  rst_sequencer #(
    .NUM_DOMAINS(3), .HOLD_CYCLES(16), .STAGE_GAP(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8)
  ) u_dut (
    .clock(clock), .reset(reset), .locked(locked), .sw_rst_req(sw_rst_req),
    .btn_rst_n(btn_rst_n), .rst_out(rst_out), .ready(ready)
  );

  rst_sequencer #(
    .NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .SYNC_STAGES(2)
  ) u_small (
    .clock(clock), .reset(reset), .locked(locked1), .sw_rst_req(sw1),
    .btn_rst_n(btn1), .rst_out(rst1), .ready(ready1)
  );

  // Reset is released on a falling edge, so the next rising edge is edge 1.
  task automatic rst_pulse();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    total++;
    if (rst_out !== 3'b111 || ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_main: rst_out=%b ready=%b want rst_out=111 ready=0", rst_out, ready);
    end
    total++;
    if (rst1 !== 1'b1 || ready1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_small: rst_out=%b ready=%b want rst_out=1 ready=0", rst1, ready1);
    end
    reset = 1'b0;
  endtask

  // locked_s is first sampled high at edge 3, so release lands at edges 18/22/26.
  task automatic test_sequence();
    exp_t e;
    locked = 1'b1;
    rst_pulse();
    sb.push_back(exp_t'{1,  3'b111, 1'b0});
    sb.push_back(exp_t'{17, 3'b111, 1'b0});
    sb.push_back(exp_t'{18, 3'b110, 1'b0});
    sb.push_back(exp_t'{21, 3'b110, 1'b0});
    sb.push_back(exp_t'{22, 3'b100, 1'b0});
    sb.push_back(exp_t'{25, 3'b100, 1'b0});
    sb.push_back(exp_t'{26, 3'b000, 1'b1});
    sb.push_back(exp_t'{30, 3'b000, 1'b1});
    for (int n = 1; n <= 30; n++) begin
      @(posedge clock); #1;
      while (sb.size() > 0 && sb[0].edge_n == n) begin
        e = sb.pop_front();
        total++;
        if (rst_out !== e.rst || ready !== e.rdy) begin
          bad++;
          $display("FAIL sequence edge %0d: rst_out=%b ready=%b want rst_out=%b ready=%b",
                   n, rst_out, ready, e.rst, e.rdy);
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sequence leftover: pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_lock_loss();
    exp_t e;
    locked = 1'b1;
    rst_pulse();
    sb.push_back(exp_t'{22, 3'b100, 1'b0});
    sb.push_back(exp_t'{25, 3'b100, 1'b0});
    sb.push_back(exp_t'{26, 3'b111, 1'b0});
    sb.push_back(exp_t'{30, 3'b111, 1'b0});
    sb.push_back(exp_t'{45, 3'b111, 1'b0});
    sb.push_back(exp_t'{46, 3'b110, 1'b0});
    sb.push_back(exp_t'{49, 3'b110, 1'b0});
    sb.push_back(exp_t'{50, 3'b100, 1'b0});
    sb.push_back(exp_t'{53, 3'b100, 1'b0});
    sb.push_back(exp_t'{54, 3'b000, 1'b1});
    for (int n = 1; n <= 56; n++) begin
      @(posedge clock); #1;
      while (sb.size() > 0 && sb[0].edge_n == n) begin
        e = sb.pop_front();
        total++;
        if (rst_out !== e.rst || ready !== e.rdy) begin
          bad++;
          $display("FAIL lock_loss edge %0d: rst_out=%b ready=%b want rst_out=%b ready=%b",
                   n, rst_out, ready, e.rst, e.rdy);
        end
      end
      if (n == 23) locked = 1'b0;
      if (n == 28) locked = 1'b1;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL lock_loss leftover: pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_sw_req();
    exp_t e;
    locked = 1'b1;
    rst_pulse();
    sb.push_back(exp_t'{26, 3'b000, 1'b1});
    sb.push_back(exp_t'{27, 3'b000, 1'b1});
    sb.push_back(exp_t'{28, 3'b111, 1'b0});
    sb.push_back(exp_t'{43, 3'b111, 1'b0});
    sb.push_back(exp_t'{44, 3'b110, 1'b0});
    sb.push_back(exp_t'{47, 3'b110, 1'b0});
    sb.push_back(exp_t'{48, 3'b111, 1'b0});
    sb.push_back(exp_t'{52, 3'b111, 1'b0});
    sb.push_back(exp_t'{63, 3'b111, 1'b0});
    sb.push_back(exp_t'{64, 3'b110, 1'b0});
    for (int n = 1; n <= 66; n++) begin
      @(posedge clock); #1;
      while (sb.size() > 0 && sb[0].edge_n == n) begin
        e = sb.pop_front();
        total++;
        if (rst_out !== e.rst || ready !== e.rdy) begin
          bad++;
          $display("FAIL sw_req edge %0d: rst_out=%b ready=%b want rst_out=%b ready=%b",
                   n, rst_out, ready, e.rst, e.rdy);
        end
      end
      if (n == 27 || n == 47) sw_rst_req = 1'b1;
      if (n == 28 || n == 48) sw_rst_req = 1'b0;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sw_req leftover: pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    locked = 1'b1;
    rst_pulse();
    sb.push_back(exp_t'{20, 3'b110, 1'b0});
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock); #1;
      while (sb.size() > 0 && sb[0].edge_n == n) begin
        e = sb.pop_front();
        total++;
        if (rst_out !== e.rst || ready !== e.rdy) begin
          bad++;
          $display("FAIL async_pre edge %0d: rst_out=%b ready=%b want rst_out=%b ready=%b",
                   n, rst_out, ready, e.rst, e.rdy);
        end
      end
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (rst_out !== 3'b111 || ready !== 1'b0) begin
      bad++;
      $display("FAIL async_now: rst_out=%b ready=%b want rst_out=111 ready=0", rst_out, ready);
    end
    #2 reset = 1'b0;
    sb.push_back(exp_t'{17, 3'b111, 1'b0});
    sb.push_back(exp_t'{18, 3'b110, 1'b0});
    sb.push_back(exp_t'{26, 3'b000, 1'b1});
    for (int n = 1; n <= 27; n++) begin
      @(posedge clock); #1;
      while (sb.size() > 0 && sb[0].edge_n == n) begin
        e = sb.pop_front();
        total++;
        if (rst_out !== e.rst || ready !== e.rdy) begin
          bad++;
          $display("FAIL async_restart edge %0d: rst_out=%b ready=%b want rst_out=%b ready=%b",
                   n, rst_out, ready, e.rst, e.rdy);
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL async leftover: pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_single_domain();
    exp_t e;
    locked1 = 1'b1;
    rst_pulse();
    sb.push_back(exp_t'{1, 3'b001, 1'b0});
    sb.push_back(exp_t'{2, 3'b001, 1'b0});
    sb.push_back(exp_t'{3, 3'b000, 1'b1});
    sb.push_back(exp_t'{5, 3'b000, 1'b1});
    for (int n = 1; n <= 5; n++) begin
      @(posedge clock); #1;
      while (sb.size() > 0 && sb[0].edge_n == n) begin
        e = sb.pop_front();
        total++;
        if (rst1 !== e.rst[0:0] || ready1 !== e.rdy) begin
          bad++;
          $display("FAIL single edge %0d: rst_out=%b ready=%b want rst_out=%b ready=%b",
                   n, rst1, ready1, e.rst[0], e.rdy);
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL single leftover: pending=%0d want 0", sb.size());
      sb.delete();
    end
    locked1 = 1'b0;
  endtask

  // Glitch drives the button low for edges 28..32; the press for edges 51..70.
  task automatic test_button();
    exp_t e;
    locked = 1'b1;
    btn_rst_n = 1'b1;
    rst_pulse();
    sb.push_back(exp_t'{26, 3'b000, 1'b1});
    sb.push_back(exp_t'{40, 3'b000, 1'b1});
    sb.push_back(exp_t'{60, 3'b000, 1'b1});
`ifdef RST_SEQ_BTN_DEBOUNCE_EN
    sb.push_back(exp_t'{61, 3'b111, 1'b0});
    sb.push_back(exp_t'{80, 3'b111, 1'b0});
    sb.push_back(exp_t'{95, 3'b111, 1'b0});
    sb.push_back(exp_t'{96, 3'b110, 1'b0});
    sb.push_back(exp_t'{100, 3'b100, 1'b0});
    sb.push_back(exp_t'{104, 3'b000, 1'b1});
`else
    sb.push_back(exp_t'{61, 3'b000, 1'b1});
    sb.push_back(exp_t'{80, 3'b000, 1'b1});
    sb.push_back(exp_t'{96, 3'b000, 1'b1});
    sb.push_back(exp_t'{104, 3'b000, 1'b1});
`endif
    for (int n = 1; n <= 106; n++) begin
      @(posedge clock); #1;
      while (sb.size() > 0 && sb[0].edge_n == n) begin
        e = sb.pop_front();
        total++;
        if (rst_out !== e.rst || ready !== e.rdy) begin
          bad++;
          $display("FAIL button edge %0d: rst_out=%b ready=%b want rst_out=%b ready=%b",
                   n, rst_out, ready, e.rst, e.rdy);
        end
      end
      if (n == 27 || n == 50) btn_rst_n = 1'b0;
      if (n == 32 || n == 70) btn_rst_n = 1'b1;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL button leftover: pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_lock_loss();
    test_sw_req();
    test_async_reset();
    test_single_domain();
    test_button();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
